eth_frame_packager: RTL and testbench

- Parametrised successor to the single-frame Ethernet byte buffer.
- Accepts one frame's payload bytes over a valid/ready/last stream and stores them in block RAM.
- Once the frame is committed, emits preamble, SFD, MAC header, payload, zero pad to minimum length, then an enforced inter-frame gap, as a continuous MSB-first symbol stream of SYM_W bits.
- Sits between the encoder byte source and the bit-order/CRC stage feeding the RMII (SYM_W=2) or MII (SYM_W=4) PHY. FCS is not generated here.

---
 rtl/eth_pkg.sv | 32 +++
 rtl/eth_symbol_serializer.sv | 36 +++
 rtl/xilinx_true_dual_port_read_first_1_clock_ram.sv | 34 +++
 rtl/eth_frame_packager.sv | 252 +++++++++++++++++++++++++
 tb/tb_eth_frame_packager.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/eth_pkg.sv
// Shared types and constants for the Ethernet frame packager.
package eth_pkg;

   typedef enum logic [3:0] {
      IDLE,
      FILL,
      DISCARD,
      PREAMBLE,
      SFD,
      HEADER,
      PAYLOAD,
      PAD,
      GAP
   } state_t;

   localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
   localparam logic [7:0] SFD_BYTE      = 8'hD5;
   localparam int         PREAMBLE_LEN  = 7;
   localparam int         HEADER_LEN    = 14;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   // Byte idx of {DST_MAC, SRC_MAC, ETHERTYPE}, most significant byte first.
   function automatic logic [7:0] header_byte(input logic [111:0] hdr, input logic [3:0] idx);
      int base;
      base = 111 - 8 * int'(idx);
      return hdr[base -: 8];
   endfunction

endpackage

// File: rtl/eth_symbol_serializer.sv
// Shifts a loaded byte out MSB-first as SYM_W-bit symbols; next_byte marks the final symbol.
module eth_symbol_serializer #(
   parameter int SYM_W = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [7:0]       data,
   output logic [SYM_W-1:0] sym,
   output logic             next_byte
);

   localparam int SPB = 8 / SYM_W;
   localparam int CW  = $clog2(SPB);

   logic [7:0]    shreg;
   logic [CW-1:0] cnt;

   // Zeros shift in behind the data, so the symbol output idles at zero.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shreg <= '0;
         cnt   <= '0;
      end else if (load) begin
         shreg <= data;
         cnt   <= '0;
      end else begin
         shreg <= shreg << SYM_W;
         cnt   <= cnt + 1'b1;
      end
   end

   assign sym       = shreg[7 -: SYM_W];
   assign next_byte = (cnt == CW'(SPB - 1));

endmodule

// File: rtl/xilinx_true_dual_port_read_first_1_clock_ram.sv
// Single-clock dual-port block RAM, read-first, with output register on the read port.
module xilinx_true_dual_port_read_first_1_clock_ram #(
   parameter int RAM_WIDTH = 8,
   parameter int RAM_DEPTH = 1500
) (
   input  logic                         clka,
   input  logic [$clog2(RAM_DEPTH)-1:0] addra,
   input  logic [RAM_WIDTH-1:0]         dina,
   input  logic                         ena,
   input  logic                         wea,
   input  logic [$clog2(RAM_DEPTH)-1:0] addrb,
   input  logic                         enb,
   input  logic                         rstb,
   input  logic                         regceb,
   output logic [RAM_WIDTH-1:0]         doutb
);

   logic [RAM_WIDTH-1:0] ram [RAM_DEPTH];
   logic [RAM_WIDTH-1:0] ram_data_b;

   always_ff @(posedge clka) begin
      if (ena && wea) ram[addra] <= dina;
   end

   always_ff @(posedge clka) begin
      if (enb) ram_data_b <= ram[addrb];
   end

   always_ff @(posedge clka) begin
      if (rstb)        doutb <= '0;
      else if (regceb) doutb <= ram_data_b;
   end

endmodule

// File: rtl/eth_frame_packager.sv
// Buffers one frame's payload in block RAM, then streams preamble, SFD, header, payload, pad and gap.
module eth_frame_packager
   import eth_pkg::*;
#(
   parameter int          SYM_W       = 2,
   parameter int          MAX_PAYLOAD = 1500,
   parameter int          MIN_PAYLOAD = 46,
   parameter int          IFG_BYTES   = 12,
   parameter logic [47:0] DST_MAC     = 48'hF00DDEADBEEF,
   parameter logic [47:0] SRC_MAC     = 48'hF00DDEADBEEF,
   parameter logic [15:0] ETHERTYPE   = 16'h0800
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             s_valid,
   input  logic [7:0]       s_data,
   input  logic             s_last,
   output logic             s_ready,
   output logic             axiov,
   output logic [SYM_W-1:0] axiod,
   output logic             busy,
   output logic             drop
);

   localparam int CNT_MAX = max_int(max_int(MAX_PAYLOAD + 2, MIN_PAYLOAD + 1), max_int(IFG_BYTES + 1, 16));
   localparam int BW      = $clog2(CNT_MAX + 1);
   localparam int RAW     = $clog2(MAX_PAYLOAD);

   localparam logic [BW-1:0]  MAX_LEN  = BW'(MAX_PAYLOAD);
   localparam logic [BW-1:0]  MIN_LEN  = BW'(MIN_PAYLOAD);
   localparam logic [BW-1:0]  PRE_LAST = BW'(PREAMBLE_LEN - 1);
   localparam logic [BW-1:0]  HDR_LAST = BW'(HEADER_LEN - 1);
   localparam logic [BW-1:0]  IFG_LAST = BW'(IFG_BYTES - 1);
   localparam logic [111:0]   HDR      = {DST_MAC, SRC_MAC, ETHERTYPE};

   if (SYM_W != 2 && SYM_W != 4) begin : g_bad_sym_w
      $error("eth_frame_packager: SYM_W must be 2 or 4");
   end

   state_t          state;
   logic [BW-1:0]   wr_ptr, len, byte_cnt, rd_ptr;
   logic            accept, overflow, wr_en, load, next_byte, ram_step, byte_last;
   logic [7:0]      load_byte, ram_dout;
   logic [RAW-1:0]  wr_addr, rd_addr;

   assign s_ready   = (state == IDLE) || (state == FILL) || (state == DISCARD);
   assign busy      = !s_ready && (state != DISCARD);
   assign accept    = s_valid && s_ready;
   assign overflow  = (state == FILL) && (wr_ptr == MAX_LEN);
   assign wr_en     = accept && ((state == IDLE) || ((state == FILL) && !overflow));
   assign wr_addr   = wr_ptr[RAW-1:0];
   assign rd_addr   = (rd_ptr < MAX_LEN) ? rd_ptr[RAW-1:0] : '0;
   assign byte_last = (byte_cnt == len - 1'b1);

   // The RAM read pipeline only advances on ram_step, so it behaves as a two-deep
   // prefetch: two steps during HEADER prime it, then one step per payload byte consumed.
   always_comb begin
      load      = 1'b0;
      load_byte = 8'h00;
      ram_step  = 1'b0;
      case (state)
         IDLE, FILL: begin
            if (wr_en && s_last) begin
               load      = 1'b1;
               load_byte = PREAMBLE_BYTE;
            end
         end
         PREAMBLE: begin
            if (next_byte) begin
               load      = 1'b1;
               load_byte = (byte_cnt == PRE_LAST) ? SFD_BYTE : PREAMBLE_BYTE;
            end
         end
         SFD: begin
            if (next_byte) begin
               load      = 1'b1;
               load_byte = header_byte(HDR, 4'd0);
            end
         end
         HEADER: begin
            if (next_byte) begin
               load      = 1'b1;
               ram_step  = (byte_cnt < BW'(2)) || (byte_cnt == HDR_LAST);
               load_byte = (byte_cnt == HDR_LAST) ? ram_dout : header_byte(HDR, byte_cnt[3:0] + 4'd1);
            end
         end
         PAYLOAD: begin
            if (next_byte) begin
               load      = 1'b1;
               ram_step  = !byte_last;
               load_byte = byte_last ? 8'h00 : ram_dout;
            end
         end
         PAD: begin
            if (next_byte) load = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         wr_ptr   <= '0;
         len      <= '0;
         byte_cnt <= '0;
         rd_ptr   <= '0;
         axiov    <= 1'b0;
         drop     <= 1'b0;
      end else begin
         drop <= 1'b0;
         if (ram_step) rd_ptr <= rd_ptr + 1'b1;
         case (state)
            IDLE: begin
               if (accept) begin
                  if (s_last) begin
                     len      <= BW'(1);
                     byte_cnt <= '0;
                     axiov    <= 1'b1;
                     state    <= PREAMBLE;
                  end else begin
                     wr_ptr <= BW'(1);
                     state  <= FILL;
                  end
               end
            end
            FILL: begin
               if (accept) begin
                  if (overflow) begin
                     if (s_last) begin
                        drop   <= 1'b1;
                        wr_ptr <= '0;
                        state  <= IDLE;
                     end else begin
                        state <= DISCARD;
                     end
                  end else if (s_last) begin
                     len      <= wr_ptr + 1'b1;
                     wr_ptr   <= '0;
                     byte_cnt <= '0;
                     axiov    <= 1'b1;
                     state    <= PREAMBLE;
                  end else begin
                     wr_ptr <= wr_ptr + 1'b1;
                  end
               end
            end
            DISCARD: begin
               if (accept && s_last) begin
                  drop   <= 1'b1;
                  wr_ptr <= '0;
                  state  <= IDLE;
               end
            end
            PREAMBLE: begin
               if (next_byte) begin
                  if (byte_cnt == PRE_LAST) begin
                     byte_cnt <= '0;
                     state    <= SFD;
                  end else begin
                     byte_cnt <= byte_cnt + 1'b1;
                  end
               end
            end
            SFD: begin
               if (next_byte) begin
                  byte_cnt <= '0;
                  rd_ptr   <= '0;
                  state    <= HEADER;
               end
            end
            HEADER: begin
               if (next_byte) begin
                  if (byte_cnt == HDR_LAST) begin
                     byte_cnt <= '0;
                     state    <= PAYLOAD;
                  end else begin
                     byte_cnt <= byte_cnt + 1'b1;
                  end
               end
            end
            PAYLOAD: begin
               if (next_byte) begin
                  if (byte_last) begin
                     if (len < MIN_LEN) begin
                        byte_cnt <= byte_cnt + 1'b1;
                        state    <= PAD;
                     end else begin
                        byte_cnt <= '0;
                        axiov    <= 1'b0;
                        state    <= GAP;
                     end
                  end else begin
                     byte_cnt <= byte_cnt + 1'b1;
                  end
               end
            end
            PAD: begin
               // Pad continues the payload byte index up to MIN_PAYLOAD-1.
               if (next_byte) begin
                  if (byte_cnt == MIN_LEN - 1'b1) begin
                     byte_cnt <= '0;
                     axiov    <= 1'b0;
                     state    <= GAP;
                  end else begin
                     byte_cnt <= byte_cnt + 1'b1;
                  end
               end
            end
            GAP: begin
               if (next_byte) begin
                  if (byte_cnt == IFG_LAST) begin
                     byte_cnt <= '0;
                     state    <= IDLE;
                  end else begin
                     byte_cnt <= byte_cnt + 1'b1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   xilinx_true_dual_port_read_first_1_clock_ram #(
      .RAM_WIDTH (8),
      .RAM_DEPTH (MAX_PAYLOAD)
   ) u_buf (
      .clka   (clk),
      .addra  (wr_addr),
      .dina   (s_data),
      .ena    (1'b1),
      .wea    (wr_en),
      .addrb  (rd_addr),
      .enb    (ram_step),
      .rstb   (rst),
      .regceb (ram_step),
      .doutb  (ram_dout)
   );

   eth_symbol_serializer #(
      .SYM_W (SYM_W)
   ) u_ser (
      .clk       (clk),
      .rst       (rst),
      .load      (load),
      .data      (load_byte),
      .sym       (axiod),
      .next_byte (next_byte)
   );

endmodule

// File: tb/tb_eth_frame_packager.sv
// Bench for eth_frame_packager: three instances (RMII, MII, small buffer) against a byte-level frame model.
module tb_eth_frame_packager;

   localparam logic [111:0] HDR = {48'hF00DDEADBEEF, 48'hF00DDEADBEEF, 16'h0800};

   typedef struct {
      int inst;
      int len;
      int pat;
      int exp_active;
      int exp_gap;
      bit exp_drop;
   } vec_t;

   logic       clk, rst;
   logic       s_valid [3];
   logic       s_last  [3];
   logic [7:0] s_data  [3];
   logic       s_ready [3];
   logic       axiov   [3];
   logic       busy    [3];
   logic       drop    [3];
   logic [1:0] axiod_a, axiod_c;
   logic [3:0] axiod_b;
   logic [3:0] sym_k   [3];

   logic [3:0] exp_q[$];
   int         n_tests = 0;
   int         n_fail  = 0;
   vec_t       vecs[10];

   eth_frame_packager #(.SYM_W(2)) dut_a (
      .clk(clk), .rst(rst), .s_valid(s_valid[0]), .s_data(s_data[0]), .s_last(s_last[0]),
      .s_ready(s_ready[0]), .axiov(axiov[0]), .axiod(axiod_a), .busy(busy[0]), .drop(drop[0]));

   eth_frame_packager #(.SYM_W(4), .MAX_PAYLOAD(64)) dut_b (
      .clk(clk), .rst(rst), .s_valid(s_valid[1]), .s_data(s_data[1]), .s_last(s_last[1]),
      .s_ready(s_ready[1]), .axiov(axiov[1]), .axiod(axiod_b), .busy(busy[1]), .drop(drop[1]));

   eth_frame_packager #(.SYM_W(2), .MAX_PAYLOAD(16)) dut_c (
      .clk(clk), .rst(rst), .s_valid(s_valid[2]), .s_data(s_data[2]), .s_last(s_last[2]),
      .s_ready(s_ready[2]), .axiov(axiov[2]), .axiod(axiod_c), .busy(busy[2]), .drop(drop[2]));

   assign sym_k[0] = {2'b00, axiod_a};
   assign sym_k[1] = axiod_b;
   assign sym_k[2] = {2'b00, axiod_c};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached, %0d tests run", n_tests);
      $fatal(1, "watchdog");
   end

   function automatic int sym_w_of(input int k);
      return (k == 1) ? 4 : 2;
   endfunction

   function automatic int max_of(input int k);
      return (k == 0) ? 1500 : (k == 1) ? 64 : 16;
   endfunction

   task automatic check(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Expected symbol stream: whole frame as bytes, each split MSB-first into symbols.
   task automatic build_exp(input int sym_w, input logic [7:0] pl[$]);
      logic [7:0] bytes[$];
      logic [7:0] v;
      exp_q.delete();
      for (int i = 0; i < 7; i++) bytes.push_back(8'h55);
      bytes.push_back(8'hD5);
      for (int i = 0; i < 14; i++) bytes.push_back(HDR[111 - 8*i -: 8]);
      foreach (pl[i]) bytes.push_back(pl[i]);
      for (int i = pl.size(); i < 46; i++) bytes.push_back(8'h00);
      foreach (bytes[b]) begin
         for (int s = 0; s < 8 / sym_w; s++) begin
            v = bytes[b] << (s * sym_w);
            exp_q.push_back((sym_w == 2) ? {2'b00, v[7:6]} : v[7:4]);
         end
      end
   endtask

   task automatic send_byte(input int k, input logic [7:0] d, input logic last, input int max_idle);
      int w;
      repeat ($urandom_range(max_idle, 0)) begin @(posedge clk); #1; end
      s_valid[k] = 1'b1;
      s_data[k]  = d;
      s_last[k]  = last;
      w = 0;
      do begin @(negedge clk); w++; end while (!s_ready[k] && w < 400);
      if (!s_ready[k]) begin
         n_tests++;
         n_fail++;
         $display("FAIL ready_timeout: inst %0d s_ready stayed 0 for %0d cycles, required 1", k, w);
      end
      @(posedge clk); #1;
      s_valid[k] = 1'b0;
      s_last[k]  = 1'b0;
   endtask

   task automatic send_frame(input int k, input logic [7:0] pl[$], input int max_idle);
      foreach (pl[i]) send_byte(k, pl[i], (i == pl.size() - 1), max_idle);
   endtask

   task automatic check_frame(input string tag, input int k, input int exp_active, input int exp_gap);
      int w = 0, n_act = 0, n_bad = 0, first_bad = -1, ready_err = 0, n_gap = 0, gap_err = 0;
      logic [3:0] want;
      do begin @(negedge clk); w++; end while (!axiov[k] && w < 50);
      check({tag, "_axiov_latency"}, w, 1);
      if (!axiov[k]) return;
      while (axiov[k] && n_act < 10000) begin
         want = (exp_q.size() > 0) ? exp_q.pop_front() : 4'hF;
         if (sym_k[k] !== want) begin
            n_bad++;
            if (first_bad < 0) begin
               first_bad = n_act;
               $display("  %s first symbol error at %0d: got %h, want %h", tag, n_act, sym_k[k], want);
            end
         end
         if (s_ready[k] || !busy[k]) ready_err++;
         n_act++;
         @(negedge clk);
      end
      check({tag, "_active_len"}, n_act, exp_active);
      check({tag, "_symbol_errs"}, n_bad, 0);
      check({tag, "_ready_busy_tx"}, ready_err, 0);
      while (!s_ready[k] && n_gap < 500) begin
         if (sym_k[k] != 4'h0 || axiov[k] || !busy[k]) gap_err++;
         n_gap++;
         @(negedge clk);
      end
      check({tag, "_gap_len"}, n_gap, exp_gap);
      check({tag, "_gap_idle"}, gap_err, 0);
      check({tag, "_busy_after"}, int'(busy[k]), 0);
   endtask

   task automatic check_drop(input string tag, input int k);
      int pulses = 0, first = -1, act = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (drop[k]) begin
            pulses++;
            if (first < 0) first = i;
         end
         if (axiov[k]) act++;
      end
      check({tag, "_drop_count"}, pulses, 1);
      check({tag, "_drop_timing"}, first, 0);
      check({tag, "_no_tx"}, act, 0);
      check({tag, "_ready_after"}, int'(s_ready[k]), 1);
   endtask

   task automatic make_payload(input int len, input int pat, output logic [7:0] pl[$]);
      pl.delete();
      for (int i = 0; i < len; i++)
         pl.push_back((pat == 0) ? 8'(i) : (pat == 1) ? 8'hA5 : 8'($urandom_range(255, 0)));
   endtask

   task automatic run_frame(input string tag, input int k, input logic [7:0] pl[$],
                            input int exp_active, input int exp_gap, input bit exp_drop, input int max_idle);
      send_frame(k, pl, max_idle);
      if (exp_drop) begin
         check_drop(tag, k);
      end else begin
         build_exp(sym_w_of(k), pl);
         check_frame(tag, k, exp_active, exp_gap);
      end
      @(posedge clk); #1;
   endtask

   initial begin
      logic [7:0] pl[$];
      int k, len, act, mx;

      vecs[0] = '{0, 60,   0, 328,  48, 1'b0};
      vecs[1] = '{0, 1,    1, 272,  48, 1'b0};
      vecs[2] = '{1, 46,   2, 136,  24, 1'b0};
      vecs[3] = '{1, 47,   2, 138,  24, 1'b0};
      vecs[4] = '{2, 20,   0, 0,    0,  1'b1};
      vecs[5] = '{2, 4,    0, 272,  48, 1'b0};
      vecs[6] = '{2, 16,   2, 272,  48, 1'b0};
      vecs[7] = '{2, 17,   2, 0,    0,  1'b1};
      vecs[8] = '{0, 1500, 2, 6088, 48, 1'b0};
      vecs[9] = '{0, 45,   2, 272,  48, 1'b0};

      // Clock/reset
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         s_valid[i] = 1'b0;
         s_last[i]  = 1'b0;
         s_data[i]  = 8'h00;
      end
      repeat (3) @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         check($sformatf("reset_s_ready_%0d", i), int'(s_ready[i]), 1);
         check($sformatf("reset_axiov_%0d", i), int'(axiov[i]), 0);
         check($sformatf("reset_busy_%0d", i), int'(busy[i]), 0);
         check($sformatf("reset_drop_%0d", i), int'(drop[i]), 0);
         check($sformatf("reset_axiod_%0d", i), int'(sym_k[i]), 0);
      end
      rst = 1'b0;
      @(posedge clk); #1;

      // Directed vector table
      for (int v = 0; v < 10; v++) begin
         make_payload(vecs[v].len, vecs[v].pat, pl);
         run_frame($sformatf("vec%0d", v), vecs[v].inst, pl, vecs[v].exp_active,
                   vecs[v].exp_gap, vecs[v].exp_drop, (vecs[v].len > 100) ? 0 : 2);
      end

      // s_valid held across the whole transmission: the next byte is taken only in IDLE
      make_payload(10, 0, pl);
      send_frame(0, pl, 0);
      s_valid[0] = 1'b1;
      s_data[0]  = 8'h3C;
      s_last[0]  = 1'b1;
      build_exp(2, pl);
      check_frame("hold_first", 0, 272, 48);
      @(posedge clk); #1;
      s_valid[0] = 1'b0;
      s_last[0]  = 1'b0;
      pl.delete();
      pl.push_back(8'h3C);
      build_exp(2, pl);
      check_frame("hold_second", 0, 272, 48);
      @(posedge clk); #1;

      // Reset in the middle of PAYLOAD
      make_payload(50, 2, pl);
      send_frame(0, pl, 0);
      repeat (100) @(negedge clk);
      check("rst_pre_active", int'(axiov[0]), 1);
      #2 rst = 1'b1;
      #1;
      check("rst_axiov_async", int'(axiov[0]), 0);
      check("rst_busy_async", int'(busy[0]), 0);
      check("rst_ready_async", int'(s_ready[0]), 1);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      act = 0;
      repeat (60) begin
         @(negedge clk);
         if (axiov[0]) act++;
      end
      check("rst_no_resume", act, 0);
      @(posedge clk); #1;
      make_payload(8, 2, pl);
      run_frame("post_rst", 0, pl, 272, 48, 1'b0, 1);

      // Randomized frames
      for (int r = 0; r < 9; r++) begin
         k   = $urandom_range(2, 0);
         mx  = max_of(k);
         len = $urandom_range((k == 2) ? 20 : (k == 1) ? 64 : 80, 1);
         make_payload(len, 2, pl);
         run_frame($sformatf("rnd%0d", r), k, pl,
                   (22 + ((len > 46) ? len : 46)) * 8 / sym_w_of(k),
                   12 * 8 / sym_w_of(k), (len > mx), 2);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
